// File: rtl/ldl_fifo_rd_stream_v1_pkg.sv
// -----------------------------------------------------------------------------
// ldl_pkg
// Shared constants and helpers for the FIFO read-stream adapter.
//   RL_MIN / RL_MAX : legal range of the FIFO read latency parameter
//   clog2_p1(n)     : bits needed to hold the values 0..n
// -----------------------------------------------------------------------------
package ldl_pkg;

    localparam int unsigned RL_MIN = 1;
    localparam int unsigned RL_MAX = 3;

    // Smallest r with 2**r >= n+1, so a counter of r bits can reach n.
    function automatic int unsigned clog2_p1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < (64'(n) + 64'(1))) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ldl_fifo_rd_stream_v1_skid_ring.sv
// -----------------------------------------------------------------------------
// ldl_skid_ring_v1
// Small ring buffer that absorbs words returning from the FIFO while the
// stream consumer stalls. Storage is not reset; pointers and occupancy are.
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_din at the write pointer
//   i_din      : word to store
//   i_pop      : retire the word at the read pointer
//   o_full_c   : occupancy equals DEPTH (combinational from state)
//   o_empty_c  : occupancy is zero (combinational from state)
//   o_occ      : number of words held
//   o_dout_c   : word at the read pointer (combinational from state)
// -----------------------------------------------------------------------------
module ldl_skid_ring_v1
    import ldl_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned OW    = clog2_p1(DEPTH),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic          o_full_c,
    output logic          o_empty_c,
    output logic [OW-1:0] o_occ,
    output logic [DW-1:0] o_dout_c
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [OW-1:0] r_occ;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Explicit wrap so non-power-of-two depths roll over at DEPTH-1.
    always_comb begin
        w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
        w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    end

    // Storage: data registers carry no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (i_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ     = r_occ;
    assign o_full_c  = (r_occ == OW'(DEPTH));
    assign o_empty_c = (r_occ == '0);
    assign o_dout_c  = r_mem[r_rptr];

    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        r_occ <= OW'(DEPTH));

endmodule

// File: rtl/ldl_fifo_rd_stream_v1.sv
// -----------------------------------------------------------------------------
// ldl_fifo_rd_stream_v1
// Converts the read side of a FIFO with fixed read latency RL into a
// valid/ready stream. Reads are issued only while the skid buffer can take
// every word already in flight, so nothing is dropped under backpressure and
// full throughput is reached with o_ready held high.
//   clk, rst    : read-side clock, asynchronous active-high reset
//   fifo_empty  : FIFO empty flag, honoured only when issuing a read
//   fifo_re     : FIFO read enable (combinational)
//   fifo_dout   : FIFO read data, valid RL edges after a sampled fifo_re
//   o_valid     : stream word available
//   o_ready     : stream consumer accepts
//   o_data      : stream word
//   occ         : words currently held in the skid buffer
// -----------------------------------------------------------------------------
module ldl_fifo_rd_stream_v1
    import ldl_pkg::*;
#(
    parameter  int unsigned DW = 8,
    parameter  int unsigned RL = 1,
    localparam int unsigned BD = RL + 1,
    localparam int unsigned CW = clog2_p1(BD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] occ
);

    // Credit arithmetic needs one bit beyond occ so occ+inflight cannot wrap.
    localparam int unsigned SW = CW + 1;

    if ((RL < RL_MIN) || (RL > RL_MAX)) begin : g_rl_range
        $error("ldl_fifo_rd_stream_v1: RL out of range 1..3");
    end

    logic [RL-1:0] r_inflight;
    logic          w_capture;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [SW-1:0] w_inflight_cnt;
    logic [SW-1:0] w_credit;

    // In-flight read tracker: bit i set means a read issued i+1 edges ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight[0] <= fifo_re;
            for (int i = 1; i < RL; i++) begin
                r_inflight[i] <= r_inflight[i-1];
            end
        end
    end

    assign w_capture = r_inflight[RL-1];
    assign w_pop     = o_valid & o_ready;

    // Credit: slots already claimed once this cycle's pop retires.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RL; i++) begin
            w_inflight_cnt = w_inflight_cnt + SW'(r_inflight[i]);
        end
        w_credit = SW'(occ) + w_inflight_cnt - SW'(w_pop);
    end

    assign fifo_re = ~rst & ~fifo_empty & (w_credit < SW'(BD));

    ldl_skid_ring_v1 #(
        .DW    (DW),
        .DEPTH (BD)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_capture),
        .i_din     (fifo_dout),
        .i_pop     (w_pop),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_occ     (occ),
        .o_dout_c  (o_data)
    );

    assign o_valid = ~w_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_capture && w_full && !w_pop));

endmodule

// File: tb/tb_ldl_fifo_rd_stream_v1.sv
// -----------------------------------------------------------------------------
// tb_ldl_fifo_rd_stream_v1
// Two instances: u_a (DW=8, RL=1) for streaming/first-word latency and
// u_b (DW=16, RL=2) for backpressure, simultaneous push/pop, wrap, reset
// and randomised traffic against a FIFO model with a scoreboard.
// -----------------------------------------------------------------------------
module tb_ldl_fifo_rd_stream_v1;

    localparam int unsigned B_BD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: RL=1 ----------------
    logic       a_empty, a_re, a_valid, a_ready;
    logic [7:0] a_dout, a_data;
    logic [1:0] a_occ;
    logic [7:0] a_mem [0:15];
    int         a_rd = 0;
    int         a_wr = 0;
    logic       a_hold = 1'b1;

    assign a_empty = (a_rd >= a_wr) || a_hold;

    // FIFO model, one-edge read latency
    always @(posedge clk) begin
        if (a_re) begin
            a_dout <= a_mem[a_rd];
            a_rd   <= a_rd + 1;
        end
    end

    ldl_fifo_rd_stream_v1 #(.DW(8), .RL(1)) u_a (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (a_empty),
        .fifo_re    (a_re),
        .fifo_dout  (a_dout),
        .o_valid    (a_valid),
        .o_ready    (a_ready),
        .o_data     (a_data),
        .occ        (a_occ)
    );

    // ---------------- instance B: RL=2 ----------------
    logic        b_empty, b_re, b_valid, b_ready;
    logic [15:0] b_dout, b_data, b_p1;
    logic [1:0]  b_occ;
    logic [15:0] b_mem [0:2047];
    int          b_rd = 0;
    int          b_wr = 0;
    logic        b_hold = 1'b1;
    logic [15:0] sb_q [$];
    logic [1:0]  b_if = 2'b00;
    int          b_pops = 0;

    assign b_empty = (b_rd >= b_wr) || b_hold;

    // FIFO model, two-edge read latency
    always @(posedge clk) begin
        if (b_re) begin
            b_p1 <= b_mem[b_rd];
            b_rd <= b_rd + 1;
        end
        b_dout <= b_p1;
    end

    // Expected-word queue: filled at read issue, flushed by reset
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            b_if <= 2'b00;
        end else begin
            if (b_re) sb_q.push_back(b_mem[b_rd]);
            b_if <= {b_if[0], b_re};
        end
    end

    ldl_fifo_rd_stream_v1 #(.DW(16), .RL(2)) u_b (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (b_empty),
        .fifo_re    (b_re),
        .fifo_dout  (b_dout),
        .o_valid    (b_valid),
        .o_ready    (b_ready),
        .o_data     (b_data),
        .occ        (b_occ)
    );

    // Continuous monitor for instance B
    always @(negedge clk) begin
        if (!rst) begin
            int credit;
            int exp_occ;
            credit  = int'(b_occ) + int'(b_if[0]) + int'(b_if[1]) - ((b_valid && b_ready) ? 1 : 0);
            exp_occ = sb_q.size() - int'(b_if[0]) - int'(b_if[1]);
            chk("occ_model", 32'(b_occ), 32'(exp_occ));
            if (credit >= int'(B_BD)) chk("re_at_full_credit", 32'(b_re), 32'd0);
            if (b_re) chk("re_while_empty", 32'(b_empty), 32'd0);
            if (b_valid && b_ready) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                else chk("sb_data", 32'(b_data), 32'(sb_q.pop_front()));
                b_pops++;
            end
        end
    end

    task automatic drain_b(input string tag);
        int n;
        n = 0;
        while ((b_valid || b_if != 2'b00 || b_rd < b_wr) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(b_valid || b_if != 2'b00), 32'd0);
    endtask

    initial begin
        int cnt;
        int start;
        int nxt;
        int n;

        for (int i = 0; i < 16; i++) a_mem[i] = 8'(i);
        for (int i = 0; i < 2048; i++) b_mem[i] = 16'(i * 5 + 256);
        a_ready = 1'b0;
        b_ready = 1'b0;

        // Reset: FIFO A non-empty, but reset must keep fifo_re low
        a_wr   = 16;
        a_hold = 1'b0;
        rst    = 1'b1;
        repeat (3) tick();
        chk("rst_a_re",    32'(a_re),    32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_occ",   32'(a_occ),   32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_occ",   32'(b_occ),   32'd0);
        a_hold = 1'b1;
        rst    = 1'b0;
        tick();

        // Streaming, RL=1: fifo_empty falls in cycle 0
        a_ready = 1'b1;
        a_hold  = 1'b0;
        #1;
        for (int k = 0; k < 20; k++) begin
            chk("a_re",    32'(a_re),    32'(k < 16));
            chk("a_valid", 32'(a_valid), 32'(k >= 2 && k < 18));
            if (k >= 2 && k < 18) chk("a_data", 32'(a_data), 32'(k - 2));
            tick();
        end

        // Backpressure, RL=2, FIFO holds 20 words, consumer stalled
        b_wr    = 20;
        b_ready = 1'b0;
        b_hold  = 1'b0;
        #1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (b_re) cnt++;
            if (b_valid) chk("bp_hold_data", 32'(b_data), 32'(b_mem[0]));
            tick();
        end
        chk("bp_re_pulses", 32'(cnt),     32'd3);
        chk("bp_occ",       32'(b_occ),   32'd3);
        chk("bp_valid",     32'(b_valid), 32'd1);
        chk("bp_data",      32'(b_data),  32'(b_mem[0]));

        // Release: read re-issued in the first pop cycle, no bubbles after
        b_ready = 1'b1;
        #1;
        chk("bp_release_re", 32'(b_re), 32'd1);
        for (int k = 0; k < 12; k++) begin
            chk("bp_flow_valid", 32'(b_valid), 32'd1);
            if (k >= 2) chk("simul_occ", 32'(b_occ), 32'd1);
            tick();
        end
        drain_b("bp_drain");
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Wrap: 10 words through the 3-deep ring, ready alternating
        start = b_pops;
        b_wr  = b_wr + 10;
        for (int k = 0; k < 40; k++) begin
            b_ready = ((k % 2) == 0);
            tick();
        end
        b_ready = 1'b1;
        chk("wrap_count", 32'(b_pops - start), 32'd10);
        drain_b("wrap_drain");

        // Reset with occ=2 and one read in flight
        b_ready = 1'b0;
        b_hold  = 1'b1;
        b_wr    = b_wr + 8;
        tick();
        b_hold = 1'b0;
        repeat (4) tick();
        nxt = b_rd;
        chk("rst_pre_occ", 32'(b_occ), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(b_valid), 32'd0);
        chk("rst_mid_re",    32'(b_re),    32'd0);
        chk("rst_mid_occ",   32'(b_occ),   32'd0);
        tick();
        rst     = 1'b0;
        b_ready = 1'b1;
        #1;
        chk("rst_first_re", 32'(b_re), 32'd1);
        n = 0;
        while (!b_valid && n < 10) begin
            tick();
            n++;
        end
        chk("rst_first_valid", 32'(b_valid), 32'd1);
        chk("rst_first_word",  32'(b_data),  32'(b_mem[nxt]));
        drain_b("rst_drain");

        // Random ready / empty, 1000 words
        start = b_pops;
        b_wr  = b_wr + 1000;
        n = 0;
        while ((b_pops - start) < 1000 && n < 20000) begin
            b_ready = 1'($urandom_range(0, 1));
            b_hold  = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        chk("rand_pops", 32'(b_pops - start), 32'd1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ldl_fifo_rd_stream_v1.md
LDL_FIFO_RD_STREAM_V1 -- requirements
Module: LDL_fifo_rd_stream_v1

Interface
- REQ-001 The block SHALL have parameter DW, default 8, meaning data width in bits.
- REQ-002 The block SHALL have parameter RL, default 1, legal range 1..3, meaning FIFO read latency in clk edges from sampled fifo_re to valid fifo_dout.
- REQ-003 The block SHALL derive localparam BD = RL+1 (skid buffer depth) and CW = $clog2(BD+1) (occupancy width).
- REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. Ports are listed in REQ-005 to REQ-013.
- REQ-005 `clk` SHALL be an input of width 1: the single clock (read-side clock of the async FIFO).
- REQ-006 `rst` SHALL be an input of width 1: the asynchronous active-high reset.
- REQ-007 `fifo_empty` SHALL be an input of width 1: FIFO empty flag.
- REQ-008 `fifo_re` SHALL be an output of width 1: FIFO read enable, one word per sampled high.
- REQ-009 `fifo_dout` SHALL be an input of width DW: FIFO read data, valid RL edges after the read.
- REQ-010 `o_valid` SHALL be an output of width 1: stream word available.
- REQ-011 `o_ready` SHALL be an input of width 1: stream consumer accepts.
- REQ-012 `o_data` SHALL be an output of width DW: stream word.
- REQ-013 `occ` SHALL be an output of width CW: number of words held in the skid buffer.

Function
- REQ-014 A pop SHALL occur on every edge where o_valid && o_ready; o_data SHALL be held stable while o_valid && !o_ready.
- REQ-015 The block SHALL track in-flight reads with an RL-bit shift register: bit 0 = fifo_re, shifted every edge, and output bit RL-1 = capture strobe.
- REQ-016 On the capture strobe, fifo_dout SHALL be written to buf[wptr] and wptr SHALL advance modulo BD.
- REQ-017 The block SHALL compute credit = occ + popcount(inflight) - pop.
- REQ-018 fifo_re SHALL equal !rst && !fifo_empty && (credit < BD), combinationally.
- REQ-019 occ SHALL be updated as next_occ = occ + capture - pop; a simultaneous capture and pop SHALL leave occ unchanged.
- REQ-020 o_valid SHALL equal (occ != 0), and o_data SHALL equal buf[rptr]; rptr SHALL advance modulo BD on pop.
- REQ-021 Overflow SHALL be impossible by construction (occ+inflight ≤ BD); an assertion SHALL flag occ > BD or capture with occ == BD && !pop.
- REQ-022 Pointer wrap-around: wptr and rptr SHALL wrap from BD-1 to 0, including for non-power-of-2 BD.
- REQ-023 First-word latency: with o_valid=0 and occ=0, fifo_empty falling in cycle c SHALL give fifo_re=1 in cycle c and o_valid=1 after exactly RL+1 edges.
- REQ-024 Throughput: with fifo_empty=0 and o_ready=1 continuously, steady state SHALL be one word per clk, with no bubbles.
- REQ-025 Backpressure: with o_ready=0, fifo_re SHALL stop once credit reaches BD; no word SHALL be lost or duplicated.
- REQ-026 When o_ready returns, the first pop cycle SHALL assert fifo_re in the same cycle if !fifo_empty.
- REQ-027 fifo_empty SHALL be honoured only at issue; in-flight reads SHALL always complete into the buffer regardless of later fifo_empty.
- REQ-028 Output order SHALL equal FIFO read order.

Reset
- REQ-029 On rst assertion (asynchronous), inflight, occ, wptr and rptr SHALL be cleared to 0, giving o_valid=0, occ=0 and fifo_re=0 immediately.
- REQ-030 buf contents SHALL NOT be reset; o_data is don't-care while o_valid=0.
- REQ-031 Reset mid-operation SHALL discard buffered and in-flight words; data returning from FIFO after reset release SHALL be ignored (inflight=0).
- REQ-032 The FIFO read side SHALL share the same rst.
- REQ-033 Deassertion SHALL be synchronous to clk (external synchronizer); the first fifo_re SHALL be allowed on the first edge after release.

Structure
- REQ-034 The shared package LDL_pkg SHALL hold the function clog2_p1(n) used for CW and the RL range-check constants RL_MIN=1 and RL_MAX=3.
- REQ-035 The skid buffer (register array, wptr/rptr, occ) SHALL be one sub-module, LDL_skid_ring_v1 #(DW, DEPTH), with push/pop/full/empty/occ ports.
- REQ-036 The credit logic and in-flight shift register SHALL reside in the top module.

Verification
- REQ-037 Streaming: RL=1, 16 words 0x00..0x0F preloaded, o_ready=1 -> o_valid first high 2 edges after fifo_empty falls, then 16 consecutive beats 0x00..0x0F, and fifo_re high 16 consecutive cycles.
- REQ-038 Backpressure: RL=2, o_ready=0 for 10 cycles with FIFO full -> exactly 3 fifo_re pulses, occ=3, and o_data stable at the first word; on release -> 3 buffered words then continuous flow, no gaps.
- REQ-039 Random: random o_ready (50%) and random fifo_empty toggling, 1000 words -> scoreboard match, occ never >BD, and no fifo_re while credit==BD.
- REQ-040 Simultaneous: occ=1 with capture and pop on the same edge -> occ stays 1, and o_data advances to the captured word.
- REQ-041 Reset: rst pulsed with occ=2 and 1 read in flight -> o_valid=0 and fifo_re=0 immediately; the stale return is not captured; after release the next FIFO word is the first output.
- REQ-042 Wrap: RL=2 (BD=3), 10 words with o_ready alternating 1/0 -> pointers wrap 0→1→2→0 and output order is preserved.
